// File: rtl/bus_node_fifo.sv
// rtl/bus_node_fifo.sv - bus port endpoint: host TX FIFO to arbiter, bus RX FIFO to host
// Optional BUS_NODE_ADDR_CHECK_EN: store only pushes addressed to id or broadcast.
module bus_node_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          fifo_size = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = {8{1'b1}}
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           pndng,
  output logic [pckg_sz-1:0]             D_pop,
  input  logic                           pop,
  input  logic                           push,
  input  logic [pckg_sz-1:0]             D_push,
  input  logic                           tx_wr,
  input  logic [pckg_sz-1:0]             tx_data,
  output logic                           tx_full,
  input  logic                           rx_rd,
  output logic [pckg_sz-1:0]             rx_data,
  output logic                           rx_empty,
  output logic [$clog2(fifo_size+1)-1:0] rx_count,
  output logic                           tx_ovf,
  output logic                           rx_ovf,
  output logic                           pop_err
);

  localparam int PW = $clog2(fifo_size);
  localparam int CW = $clog2(fifo_size+1);
  localparam logic [PW-1:0] PTR_LAST = PW'(fifo_size - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(fifo_size);

  logic [pckg_sz-1:0] r_tx_mem [fifo_size];
  logic [pckg_sz-1:0] r_rx_mem [fifo_size];
  logic [PW-1:0]      r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
  logic [CW-1:0]      r_tx_count, r_rx_count;
  logic               r_tx_ovf, r_rx_ovf, r_pop_err;

  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_rd_ok, w_tx_wr_ok, w_rx_rd_ok, w_rx_push_ok, w_rx_match;

  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == CNT_FULL);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == CNT_FULL);

`ifdef BUS_NODE_ADDR_CHECK_EN
  assign w_rx_match = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
`else
  assign w_rx_match = 1'b1;
`endif

  // A same-cycle read frees the slot, so a write into a full FIFO is still accepted.
  assign w_tx_rd_ok   = pop && !w_tx_empty;
  assign w_tx_wr_ok   = tx_wr && (!w_tx_full || w_tx_rd_ok);
  assign w_rx_rd_ok   = rx_rd && !w_rx_empty;
  assign w_rx_push_ok = push && w_rx_match && (!w_rx_full || w_rx_rd_ok);

  always_ff @(posedge clk) begin
    if (w_tx_wr_ok)   r_tx_mem[r_tx_wr_ptr] <= tx_data;
    if (w_rx_push_ok) r_rx_mem[r_rx_wr_ptr] <= D_push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_pop_err   <= 1'b0;
    end else begin
      if (w_tx_wr_ok)
        r_tx_wr_ptr <= (r_tx_wr_ptr == PTR_LAST) ? '0 : r_tx_wr_ptr + 1'b1;
      if (w_tx_rd_ok)
        r_tx_rd_ptr <= (r_tx_rd_ptr == PTR_LAST) ? '0 : r_tx_rd_ptr + 1'b1;
      if (w_tx_wr_ok && !w_tx_rd_ok)
        r_tx_count <= r_tx_count + 1'b1;
      else if (!w_tx_wr_ok && w_tx_rd_ok)
        r_tx_count <= r_tx_count - 1'b1;

      if (w_rx_push_ok)
        r_rx_wr_ptr <= (r_rx_wr_ptr == PTR_LAST) ? '0 : r_rx_wr_ptr + 1'b1;
      if (w_rx_rd_ok)
        r_rx_rd_ptr <= (r_rx_rd_ptr == PTR_LAST) ? '0 : r_rx_rd_ptr + 1'b1;
      if (w_rx_push_ok && !w_rx_rd_ok)
        r_rx_count <= r_rx_count + 1'b1;
      else if (!w_rx_push_ok && w_rx_rd_ok)
        r_rx_count <= r_rx_count - 1'b1;

      if (tx_wr && !w_tx_wr_ok)                r_tx_ovf  <= 1'b1;
      if (push && w_rx_match && !w_rx_push_ok) r_rx_ovf  <= 1'b1;
      if (pop && w_tx_empty)                   r_pop_err <= 1'b1;
    end
  end

  assign pndng    = !w_tx_empty;
  assign D_pop    = r_tx_mem[r_tx_rd_ptr];
  assign tx_full  = w_tx_full;
  assign rx_data  = r_rx_mem[r_rx_rd_ptr];
  assign rx_empty = w_rx_empty;
  assign rx_count = r_rx_count;
  assign tx_ovf   = r_tx_ovf;
  assign rx_ovf   = r_rx_ovf;
  assign pop_err  = r_pop_err;

endmodule
